// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the ALU stream (strict priority) and the memory stream
// (buffered in an in-order FIFO) into one registered register-file write port.
// Optional macro WB_FWD_EN adds combinational bypass ports for decode.
module wb_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wd,
  output logic [31:0] pend_mask,
  output logic        busy
`ifdef WB_FWD_EN
  ,
  input  logic [4:0]  fwd_rs1,
  input  logic [4:0]  fwd_rs2,
  output logic        fwd_hit1,
  output logic        fwd_hit2,
  output logic [31:0] fwd_data
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [4:0]    fifo_rd_mem [DEPTH];
  logic [31:0]   fifo_wd_mem [DEPTH];
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          rf_we_reg, rf_we_next;
  logic [4:0]    rf_rd_reg, rf_rd_next;
  logic [31:0]   rf_wd_reg, rf_wd_next;

  logic alu_sel, fifo_empty, mem_take, pop, push, bypass;

  always_comb begin
    alu_sel    = alu_valid && (alu_rd != 5'd0);
    fifo_empty = (count_reg == '0);
    // Readiness uses the pre-pop count, so a full FIFO never accepts.
    mem_ready  = (count_reg < CW'(DEPTH)) && !rst;
    mem_take   = mem_valid && mem_ready && (mem_rd != 5'd0);
    pop        = !alu_sel && !fifo_empty;
    bypass     = !alu_sel && fifo_empty && mem_take;
    push       = mem_take && !bypass;

    rf_we_next = 1'b0;
    rf_rd_next = rf_rd_reg;
    rf_wd_next = rf_wd_reg;
    if (alu_sel) begin
      rf_we_next = 1'b1;
      rf_rd_next = alu_rd;
      rf_wd_next = alu_data;
    end else if (pop) begin
      rf_we_next = 1'b1;
      rf_rd_next = fifo_rd_mem[rd_ptr_reg];
      rf_wd_next = fifo_wd_mem[rd_ptr_reg];
    end else if (bypass) begin
      rf_we_next = 1'b1;
      rf_rd_next = mem_rd;
      rf_wd_next = mem_data;
    end

    count_next  = count_reg + CW'(push) - CW'(pop);
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    if (pop)
      rd_ptr_next = (rd_ptr_reg == PW'(DEPTH - 1)) ? '0 : rd_ptr_reg + PW'(1);
    if (push)
      wr_ptr_next = (wr_ptr_reg == PW'(DEPTH - 1)) ? '0 : wr_ptr_reg + PW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      rf_we_reg  <= 1'b0;
      rf_rd_reg  <= 5'd0;
      rf_wd_reg  <= 32'd0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
      rf_we_reg  <= rf_we_next;
      rf_rd_reg  <= rf_rd_next;
      rf_wd_reg  <= rf_wd_next;
    end
  end

  // Payload storage needs no reset: occupancy is tracked by count/pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_mem[wr_ptr_reg] <= mem_rd;
      fifo_wd_mem[wr_ptr_reg] <= mem_data;
    end
  end

  logic [DEPTH-1:0][31:0] slot_mask;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    int slot_off;
    assign slot_off      = (gi + DEPTH - int'(rd_ptr_reg)) % DEPTH;
    assign slot_mask[gi] = (slot_off < int'(count_reg)) ? (32'd1 << fifo_rd_mem[gi]) : 32'd0;
  end

  always_comb begin
    pend_mask = rf_we_reg ? (32'd1 << rf_rd_reg) : 32'd0;
    for (int i = 0; i < DEPTH; i++)
      pend_mask = pend_mask | slot_mask[i];
    pend_mask[0] = 1'b0;
  end

  assign rf_we = rf_we_reg;
  assign rf_rd = rf_rd_reg;
  assign rf_wd = rf_wd_reg;
  assign busy  = rf_we_reg || (count_reg != '0);

`ifdef WB_FWD_EN
  assign fwd_hit1 = rf_we_reg && (rf_rd_reg == fwd_rs1) && (fwd_rs1 != 5'd0);
  assign fwd_hit2 = rf_we_reg && (rf_rd_reg == fwd_rs2) && (fwd_rs2 != 5'd0);
  assign fwd_data = rf_wd_reg;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter (DEPTH=2): vector table with per-cycle expectations plus a
// write-order scoreboard; hand sequences for mid-stream reset and forwarding.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, mem_valid;
  logic [4:0]  alu_rd, mem_rd;
  logic [31:0] alu_data, mem_data;
  logic        mem_ready, rf_we, busy;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wd, pend_mask;
`ifdef WB_FWD_EN
  logic [4:0]  fwd_rs1 = 5'd0, fwd_rs2 = 5'd0;
  logic        fwd_hit1, fwd_hit2;
  logic [31:0] fwd_data;
`endif

  wb_arbiter #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd),
    .pend_mask(pend_mask), .busy(busy)
`ifdef WB_FWD_EN
    , .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_data(fwd_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] md;
    logic        e_ready;
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_wd;
    logic [31:0] e_pend;
    logic        e_busy;
  } vec_t;

  int checks = 0;
  int failures = 0;
  logic [36:0] alu_q[$];
  logic [36:0] mem_q[$];
  vec_t tbl [16];
  vec_t idle_v;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    alu_valid = v.av; alu_rd = v.ard; alu_data = v.ad;
    mem_valid = v.mv; mem_rd = v.mrd; mem_data = v.md;
    #1;
    chk({tag, " mem_ready"}, {31'd0, mem_ready}, {31'd0, v.e_ready});
    if (v.av && v.ard != 5'd0) alu_q.push_back({v.ard, v.ad});
    if (v.mv && v.e_ready && v.mrd != 5'd0) mem_q.push_back({v.mrd, v.md});
    @(posedge clk);
    #1;
    chk({tag, " rf_we"}, {31'd0, rf_we}, {31'd0, v.e_we});
    if (v.e_we) begin
      chk({tag, " rf_rd"}, {27'd0, rf_rd}, {27'd0, v.e_rd});
      chk({tag, " rf_wd"}, rf_wd, v.e_wd);
    end
    chk({tag, " pend_mask"}, pend_mask, v.e_pend);
    chk({tag, " busy"}, {31'd0, busy}, {31'd0, v.e_busy});
    if (rf_we) begin
      checks++;
      if (alu_q.size() > 0 && alu_q[0] == {rf_rd, rf_wd}) void'(alu_q.pop_front());
      else if (mem_q.size() > 0 && mem_q[0] == {rf_rd, rf_wd}) void'(mem_q.pop_front());
      else begin
        failures++;
        $display("FAIL %s scoreboard actual=x%0d/0x%08h required=next queued write", tag, rf_rd, rf_wd);
      end
    end
    $display("%s: alu(%0b,x%0d) mem(%0b,x%0d) ready=%0b -> we=%0b rd=x%0d wd=0x%08h pend=0x%08h busy=%0b",
             tag, v.av, v.ard, v.mv, v.mrd, mem_ready, rf_we, rf_rd, rf_wd, pend_mask, busy);
  endtask

  initial begin
    //            av ard  ad            mv mrd  md           rdy we rd  wd            pend           busy
    tbl[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,   1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 32'h0000_0020, 1'b1};
    tbl[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,   1'b1, 1'b0, 5'd0, 32'h0,        32'h0,         1'b0};
    tbl[2]  = '{1'b1, 5'd3, 32'h11,       1'b1, 5'd7, 32'h22,  1'b1, 1'b1, 5'd3, 32'h11,       32'h0000_0088, 1'b1};
    tbl[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,   1'b1, 1'b1, 5'd7, 32'h22,       32'h0000_0080, 1'b1};
    tbl[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,   1'b1, 1'b0, 5'd0, 32'h0,        32'h0,         1'b0};
    tbl[5]  = '{1'b1, 5'd1, 32'h100,      1'b1, 5'd8, 32'h800, 1'b1, 1'b1, 5'd1, 32'h100,      32'h0000_0102, 1'b1};
    tbl[6]  = '{1'b1, 5'd1, 32'h101,      1'b1, 5'd9, 32'h900, 1'b1, 1'b1, 5'd1, 32'h101,      32'h0000_0302, 1'b1};
    tbl[7]  = '{1'b1, 5'd1, 32'h102,      1'b1, 5'd10, 32'hA00, 1'b0, 1'b1, 5'd1, 32'h102,     32'h0000_0302, 1'b1};
    tbl[8]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd10, 32'hA00, 1'b0, 1'b1, 5'd8, 32'h800,     32'h0000_0300, 1'b1};
    tbl[9]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd10, 32'hA00, 1'b1, 1'b1, 5'd9, 32'h900,     32'h0000_0600, 1'b1};
    tbl[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,   1'b1, 1'b1, 5'd10, 32'hA00,     32'h0000_0400, 1'b1};
    tbl[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,   1'b1, 1'b0, 5'd0, 32'h0,        32'h0,         1'b0};
    tbl[12] = '{1'b1, 5'd0, 32'h77,       1'b1, 5'd0, 32'h66,  1'b1, 1'b0, 5'd0, 32'h0,        32'h0,         1'b0};
    tbl[13] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'h55,  1'b1, 1'b0, 5'd0, 32'h0,        32'h0,         1'b0};
    tbl[14] = '{1'b1, 5'd0, 32'h99,       1'b1, 5'd12, 32'hC,  1'b1, 1'b1, 5'd12, 32'hC,       32'h0000_1000, 1'b1};
    tbl[15] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,   1'b1, 1'b0, 5'd0, 32'h0,        32'h0,         1'b0};
    idle_v  = tbl[1];

    rst = 1'b1;
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    mem_valid = 1'b0; mem_rd = 5'd0; mem_data = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset rf_we", {31'd0, rf_we}, 32'd0);
    chk("reset rf_rd", {27'd0, rf_rd}, 32'd0);
    chk("reset rf_wd", rf_wd, 32'd0);
    chk("reset pend_mask", pend_mask, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset mem_ready", {31'd0, mem_ready}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) apply(tbl[i], $sformatf("vec%0d", i));

`ifdef WB_FWD_EN
    apply('{1'b1, 5'd4, 32'h55, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 5'd4, 32'h55, 32'h10, 1'b1}, "fwd_load");
    fwd_rs1 = 5'd4; fwd_rs2 = 5'd0;
    #1;
    chk("fwd_hit1", {31'd0, fwd_hit1}, 32'd1);
    chk("fwd_hit2", {31'd0, fwd_hit2}, 32'd0);
    chk("fwd_data", fwd_data, 32'h55);
    apply(idle_v, "fwd_idle");
    chk("fwd_hit1 idle", {31'd0, fwd_hit1}, 32'd0);
`endif

    // Mid-stream reset with two FIFO entries and a live output write.
    apply('{1'b1, 5'd1, 32'h1111, 1'b1, 5'd20, 32'h2020, 1'b1, 1'b1, 5'd1, 32'h1111, 32'h0010_0002, 1'b1}, "rstA");
    apply('{1'b1, 5'd2, 32'h2222, 1'b1, 5'd21, 32'h2121, 1'b1, 1'b1, 5'd2, 32'h2222, 32'h0030_0004, 1'b1}, "rstB");
    alu_valid = 1'b0; mem_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst rf_we", {31'd0, rf_we}, 32'd0);
    chk("midrst rf_rd", {27'd0, rf_rd}, 32'd0);
    chk("midrst rf_wd", rf_wd, 32'd0);
    chk("midrst pend_mask", pend_mask, 32'd0);
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst mem_ready", {31'd0, mem_ready}, 32'd0);
    $display("midrst: rst asserted, we=%0b pend=0x%08h busy=%0b ready=%0b", rf_we, pend_mask, busy, mem_ready);
    mem_q.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) apply(idle_v, $sformatf("postrst%0d", i));

    chk("scoreboard alu_q drained", alu_q.size(), 32'd0);
    chk("scoreboard mem_q drained", mem_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
